// File: rtl/glbl_reg_bank.sv
// glbl_reg_bank: global register bank on the shared reg-bus.
// Holds the chip config words, the sticky interrupt status with its mask, a
// one-way write lock and a timed soft-reset pulse generator. Every accepted
// bus transaction is acked one cycle later with registered read data.
module glbl_reg_bank #(
  parameter int unsigned                NUM_CFG     = 4,
  parameter logic [NUM_CFG*32-1:0]      CFG_RST     = {NUM_CFG{32'h0}},
  parameter int unsigned                NUM_IRQ     = 8,
  parameter logic [31:0]                CHIP_ID     = 32'h4C66_8354,
  parameter logic [31:0]                REL_DATE    = 32'h1603_2022,
  parameter logic [31:0]                PROJ_REV    = 32'h0001_6000,
  parameter int unsigned                SRST_CYCLES = 4
) (
  input  logic                  mclk,
  input  logic                  reset_n,
  input  logic                  reg_cs,
  input  logic                  reg_wr,
  input  logic [7:0]            reg_addr,
  input  logic [31:0]           reg_wdata,
  input  logic [3:0]            reg_be,
  output logic [31:0]           reg_rdata,
  output logic                  reg_ack,
  input  logic [NUM_IRQ-1:0]    irq_evt,
  output logic [NUM_CFG*32-1:0] cfg_out,
  output logic                  irq_o,
  output logic                  soft_rst_n,
  output logic                  cfg_locked
);

  localparam logic [3:0]  W_STS  = 4'd8;
  localparam logic [3:0]  W_MASK = 4'd9;
  localparam logic [3:0]  W_CHIP = 4'd11;
  localparam logic [3:0]  W_DATE = 4'd12;
  localparam logic [3:0]  W_REV  = 4'd13;
  localparam logic [3:0]  W_LOCK = 4'd14;

  localparam logic [3:0]  W_SRST = 4'd15;

  // Only the implemented interrupt sources can ever hold a status or mask bit.
  localparam logic [31:0] IRQ_VALID = 32'((64'd1 << NUM_IRQ) - 64'd1);
  localparam logic [7:0]  SRST_LOAD = 8'(SRST_CYCLES);

  logic [3:0]  word;
  logic        accept;
  logic        wr_acc;
  logic [31:0] be_mask;
  logic [31:0] rd_mux;
  logic [31:0] evt_ext;
  logic [31:0] sts_clr;
  logic        lock_set;
  logic        srst_go;

  logic [31:0] cfg_q [NUM_CFG];
  logic [31:0] sts_q;
  logic [31:0] mask_q;
  logic        lock_q;
  logic [7:0]  srst_cnt;

  // Byte-lane select bits and the word-aligned offset are not part of the decode.
  logic unused_addr;
  assign unused_addr = ^{reg_addr[7:6], reg_addr[1:0]};

  assign word     = reg_addr[5:2];
  // A transaction is taken only while no ack is outstanding, so a master that
  // keeps reg_cs high gets a fresh transaction every second cycle.
  assign accept   = reg_cs & ~reg_ack;
  assign wr_acc   = accept & reg_wr;
  assign be_mask  = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};
  assign evt_ext  = 32'(irq_evt);
  assign sts_clr  = (wr_acc && (word == W_STS)) ? (reg_wdata & be_mask) : 32'h0;
  assign lock_set = wr_acc && (word == W_LOCK) && reg_be[0] && reg_wdata[0];
  assign srst_go  = wr_acc && (word == W_SRST) && reg_be[0] && reg_wdata[0];

  assign cfg_locked = lock_q;

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
    assign cfg_out[32*g +: 32] = cfg_q[g];
  end

  // Read mux: value of the addressed word before the accepting edge.
  always_comb begin
    rd_mux = 32'h0;
    case (word)
      W_STS:   rd_mux = sts_q;
      W_MASK:  rd_mux = mask_q;
      W_CHIP:  rd_mux = CHIP_ID;
      W_DATE:  rd_mux = REL_DATE;
      W_REV:   rd_mux = PROJ_REV;
      W_LOCK:  rd_mux = {31'd0, lock_q};
      default: begin
        for (int k = 0; k < NUM_CFG; k++) begin
          if (word == 4'(k)) rd_mux = cfg_q[k];
        end
      end
    endcase
  end

  // Bus response: one-cycle ack, read data captured only on accepted edges.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      reg_ack   <= 1'b0;
      reg_rdata <= 32'h0;
    end else begin
      reg_ack <= accept;
      if (accept) reg_rdata <= rd_mux;
    end
  end

  // Config words: byte-masked writes, dropped entirely once the bank is locked.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= CFG_RST[32*k +: 32];
    end else if (wr_acc && !lock_q) begin
      for (int k = 0; k < NUM_CFG; k++) begin
        if (word == 4'(k)) cfg_q[k] <= (cfg_q[k] & ~be_mask) | (reg_wdata & be_mask);
      end
    end
  end

  // Interrupt mask, also frozen by the lock.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= 32'h0;
    end else if (wr_acc && (word == W_MASK) && !lock_q) begin
      mask_q <= ((mask_q & ~be_mask) | (reg_wdata & be_mask)) & IRQ_VALID;
    end
  end

  // Sticky status: a new event in the same cycle as its clear keeps the bit set.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sts_q <= 32'h0;
    end else begin
      sts_q <= ((sts_q & ~sts_clr) | evt_ext) & IRQ_VALID;
    end
  end

  // Interrupt line registered from the current status and mask.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |(sts_q & mask_q);
    end
  end

  // Lock bit: set-only, cleared solely by reset_n.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= 1'b0;
    end else if (lock_set) begin
      lock_q <= 1'b1;
    end
  end

  // Soft-reset timer: down-counter, output low while non-zero; a write while
  // running reloads it so the pulse is stretched from the latest write.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      srst_cnt   <= 8'd0;
      soft_rst_n <= 1'b1;
    end else begin
      if (srst_go) begin
        srst_cnt <= SRST_LOAD;
      end else if (srst_cnt != 8'd0) begin
        srst_cnt <= srst_cnt - 8'd1;
      end
      soft_rst_n <= (srst_cnt == 8'd0);
    end
  end

endmodule

// File: tb/tb_glbl_reg_bank.sv
// Bench for glbl_reg_bank: vector table, hand sequences for interrupt, lock,
// soft-reset and async-reset corners, then random traffic against a model.
module tb_glbl_reg_bank;

  localparam int unsigned NUM_CFG = 4;
  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned SRST_CYCLES = 4;
  localparam logic [127:0] CFG_RST = {32'hC0DE_0003, 32'h0BAD_F00D, 32'h0000_0000, 32'h1234_ABCD};
  localparam int unsigned MAXC = 8192;

  logic                  mclk;
  logic                  reset_n;
  logic                  reg_cs;
  logic                  reg_wr;
  logic [7:0]            reg_addr;
  logic [31:0]           reg_wdata;
  logic [3:0]            reg_be;
  logic [31:0]           reg_rdata;
  logic                  reg_ack;
  logic [NUM_IRQ-1:0]    irq_evt;
  logic [NUM_CFG*32-1:0] cfg_out;
  logic                  irq_o;
  logic                  soft_rst_n;
  logic                  cfg_locked;

  glbl_reg_bank #(
    .NUM_CFG(NUM_CFG), .CFG_RST(CFG_RST), .NUM_IRQ(NUM_IRQ), .SRST_CYCLES(SRST_CYCLES)
  ) dut (
    .mclk(mclk), .reset_n(reset_n), .reg_cs(reg_cs), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .irq_evt(irq_evt),
    .cfg_out(cfg_out), .irq_o(irq_o), .soft_rst_n(soft_rst_n), .cfg_locked(cfg_locked)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_cfg [NUM_CFG];
  logic [31:0] m_sts, m_mask, m_rdata;
  logic        m_lock, m_ack, m_irq;
  int          cyc = 0;
  bit          exp_low [MAXC];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] w);
    if (w < 4'(NUM_CFG)) return m_cfg[w[1:0]];
    case (w)
      4'd8:  return m_sts;
      4'd9:  return m_mask;
      4'd11: return 32'h4C66_8354;
      4'd12: return 32'h1603_2022;
      4'd13: return 32'h0001_6000;
      4'd14: return {31'd0, m_lock};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [127:0] model_cfg();
    logic [127:0] p;
    for (int k = 0; k < NUM_CFG; k++) p[32*k +: 32] = m_cfg[k];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CFG; k++) m_cfg[k] = CFG_RST[32*k +: 32];
    m_sts = 0; m_mask = 0; m_rdata = 0; m_lock = 0; m_ack = 0; m_irq = 0;
    foreach (exp_low[i]) exp_low[i] = 1'b0;
  endtask

  // Apply the register-bank rules for one rising edge, using pre-edge state.
  task automatic model_edge();
    logic [3:0]  w;
    logic [31:0] bm, clr;
    logic        acc, irq_n;
    cyc++;
    w     = reg_addr[5:2];
    bm    = bmask(reg_be);
    acc   = reg_cs && !m_ack;
    irq_n = |(m_sts & m_mask);
    clr   = 0;
    if (acc) begin
      m_rdata = model_read(w);
      if (reg_wr) begin
        if (w < 4'(NUM_CFG) && !m_lock) m_cfg[w[1:0]] = (m_cfg[w[1:0]] & ~bm) | (reg_wdata & bm);
        if (w == 4'd9 && !m_lock) m_mask = ((m_mask & ~bm) | (reg_wdata & bm)) & 32'hFF;
        if (w == 4'd8) clr = reg_wdata & bm;
        if (w == 4'd14 && reg_be[0] && reg_wdata[0]) m_lock = 1'b1;
        if (w == 4'd15 && reg_be[0] && reg_wdata[0])
          for (int k = 1; k <= SRST_CYCLES; k++) if (cyc + k < MAXC) exp_low[cyc + k] = 1'b1;
      end
    end
    m_sts = ((m_sts & ~clr) | 32'(irq_evt)) & 32'hFF;
    m_ack = acc;
    m_irq = irq_n;
  endtask

  task automatic step();
    @(posedge mclk);
    model_edge();
    #1;
    chk("reg_ack", reg_ack, m_ack);
    chk("reg_rdata", reg_rdata, m_rdata);
    chk("cfg_out", cfg_out, model_cfg());
    chk("irq_o", irq_o, m_irq);
    chk("soft_rst_n", soft_rst_n, !exp_low[cyc]);
    chk("cfg_locked", cfg_locked, m_lock);
    @(negedge mclk);
  endtask

  task automatic txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input logic [NUM_IRQ-1:0] evt, output logic [31:0] rd);
    int n;
    n = 0;
    reg_cs = 1'b1; reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_be = be; irq_evt = evt;
    do begin
      step();
      irq_evt = '0;
      n++;
    end while (!reg_ack && n < 4);
    chk("ack_latency", n, 1);
    rd = reg_rdata;
    reg_cs = 1'b0; reg_wr = 1'b0;
    step();
  endtask

  task automatic count_srst_low(input string nm);
    int cnt, guard;
    cnt = (soft_rst_n == 1'b0) ? 1 : 0;
    guard = 0;
    while (soft_rst_n == 1'b0 && guard < 20) begin
      step();
      if (soft_rst_n == 1'b0) cnt++;
      guard++;
    end
    chk(nm, cnt, SRST_CYCLES);
  endtask

  task automatic rand_phase(input int n, input bit allow_lock);
    logic [3:0] wl [15];
    logic [3:0] w;
    wl = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd8, 4'd9, 4'd9, 4'd10, 4'd11, 4'd13, 4'd15, 4'd14};
    for (int i = 0; i < n; i++) begin
      w = wl[$urandom_range(0, allow_lock ? 14 : 13)];
      reg_cs    = ($urandom_range(0, 2) != 0);
      reg_wr    = 1'($urandom_range(0, 1));
      reg_addr  = {2'($urandom), w, 2'($urandom)};
      reg_wdata = $urandom;
      reg_be    = 4'($urandom);
      irq_evt   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step();
    end
    reg_cs = 1'b0; reg_wr = 1'b0; irq_evt = '0;
    step();
    step();
  endtask

  initial begin
    logic [31:0] rd;
    reset_n = 1'b1; reg_cs = 0; reg_wr = 0; reg_addr = 0; reg_wdata = 0; reg_be = 0; irq_evt = '0;
    model_reset();

    tbl[0]  = '{1'b0, 8'h00, 32'h0,         4'hF, 1'b1, 32'h1234_ABCD};
    tbl[1]  = '{1'b0, 8'h2C, 32'h0,         4'hF, 1'b1, 32'h4C66_8354};
    tbl[2]  = '{1'b0, 8'h30, 32'h0,         4'hF, 1'b1, 32'h1603_2022};
    tbl[3]  = '{1'b0, 8'h34, 32'h0,         4'hF, 1'b1, 32'h0001_6000};
    tbl[4]  = '{1'b0, 8'h24, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    tbl[5]  = '{1'b1, 8'h04, 32'hDEAD_BEEF, 4'h5, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 8'h04, 32'h0,         4'hF, 1'b1, 32'h00AD_00EF};
    tbl[7]  = '{1'b0, 8'hC7, 32'h0,         4'hF, 1'b1, 32'h00AD_00EF};
    tbl[8]  = '{1'b1, 8'h2C, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 8'h2C, 32'h0,         4'hF, 1'b1, 32'h4C66_8354};
    tbl[10] = '{1'b0, 8'h28, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    tbl[11] = '{1'b1, 8'h3C, 32'hFFFF_FFFE, 4'hF, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 8'h3C, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    tbl[13] = '{1'b1, 8'h0C, 32'hAAAA_5555, 4'hC, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 8'h0C, 32'h0,         4'hF, 1'b1, 32'hAAAA_0003};
    tbl[15] = '{1'b0, 8'h08, 32'h0,         4'hF, 1'b1, 32'h0BAD_F00D};
    tbl[16] = '{1'b1, 8'h18, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    tbl[17] = '{1'b0, 8'h18, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    tbl[18] = '{1'b0, 8'h38, 32'h0,         4'hF, 1'b1, 32'h0000_0000};

    // Power-on reset
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ack", reg_ack, 1'b0);
    chk("rst_rdata", reg_rdata, 32'h0);
    chk("rst_cfg_out", cfg_out, CFG_RST);
    chk("rst_irq_o", irq_o, 1'b0);
    chk("rst_soft_rst_n", soft_rst_n, 1'b1);
    chk("rst_locked", cfg_locked, 1'b0);
    @(negedge mclk); @(negedge mclk);
    reset_n = 1'b1;
    step();

    // Vector table
    for (int i = 0; i < 19; i++) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, '0, rd);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
      if (i == 5) chk("cfg1_out", cfg_out[63:32], 32'h00AD_00EF);
    end

    // Interrupt: sticky status, mask, set-beats-clear
    irq_evt = 8'h08;
    step();
    irq_evt = '0;
    txn(1'b0, 8'h20, 32'h0, 4'hF, '0, rd);
    chk("sts_after_evt", rd, 32'h8);
    chk("irq_masked_off", irq_o, 1'b0);
    txn(1'b1, 8'h24, 32'h8, 4'hF, '0, rd);
    chk("irq_after_mask", irq_o, 1'b1);
    txn(1'b1, 8'h20, 32'h8, 4'h1, 8'h08, rd);
    txn(1'b0, 8'h20, 32'h0, 4'hF, '0, rd);
    chk("sts_set_wins", rd, 32'h8);
    txn(1'b1, 8'h20, 32'h8, 4'h1, '0, rd);
    txn(1'b0, 8'h20, 32'h0, 4'hF, '0, rd);
    chk("sts_w1c", rd, 32'h0);
    chk("irq_after_clear", irq_o, 1'b0);

    // Soft reset pulse and extension
    txn(1'b1, 8'h3C, 32'h1, 4'h1, '0, rd);
    count_srst_low("srst_len");
    txn(1'b1, 8'h3C, 32'h1, 4'h1, '0, rd);
    txn(1'b1, 8'h3C, 32'h1, 4'h1, '0, rd);
    count_srst_low("srst_extend_len");

    // Random traffic, unlocked
    rand_phase(300, 1'b0);

    // Lock
    txn(1'b1, 8'h38, 32'h1, 4'h1, '0, rd);
    chk("locked", cfg_locked, 1'b1);
    txn(1'b0, 8'h00, 32'h0, 4'hF, '0, rd);
    begin
      logic [31:0] cfg0_before, mask_before;
      cfg0_before = m_cfg[0];
      mask_before = m_mask;
      txn(1'b1, 8'h00, 32'h1234_5678, 4'hF, '0, rd);
      txn(1'b1, 8'h24, 32'hFF, 4'hF, '0, rd);
      txn(1'b0, 8'h00, 32'h0, 4'hF, '0, rd);
      chk("lock_cfg0_kept", rd, cfg0_before);
      txn(1'b0, 8'h24, 32'h0, 4'hF, '0, rd);
      chk("lock_mask_kept", rd, mask_before);
    end
    txn(1'b0, 8'h38, 32'h0, 4'hF, '0, rd);
    chk("lock_read", rd, 32'h1);
    irq_evt = 8'h10;
    step();
    irq_evt = '0;
    txn(1'b1, 8'h20, 32'hFF, 4'h1, '0, rd);
    txn(1'b0, 8'h20, 32'h0, 4'hF, '0, rd);
    chk("lock_sts_clear", rd, 32'h0);

    // Random traffic, locked
    rand_phase(300, 1'b1);

    // Async reset during a transaction ack and a soft-reset pulse
    txn(1'b1, 8'h3C, 32'h1, 4'h1, '0, rd);
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 8'h04; reg_wdata = 32'h5555_5555; reg_be = 4'hF;
    step();
    chk("pre_rst_ack", reg_ack, 1'b1);
    chk("pre_rst_soft", soft_rst_n, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ack", reg_ack, 1'b0);
    chk("mid_rst_soft", soft_rst_n, 1'b1);
    chk("mid_rst_locked", cfg_locked, 1'b0);
    chk("mid_rst_cfg_out", cfg_out, CFG_RST);
    chk("mid_rst_irq_o", irq_o, 1'b0);
    @(posedge mclk); #1;
    chk("in_rst_no_ack", reg_ack, 1'b0);
    @(negedge mclk);
    reg_cs = 1'b0; reg_wr = 1'b0;
    reset_n = 1'b1;
    step();
    txn(1'b0, 8'h04, 32'h0, 4'hF, '0, rd);
    chk("post_rst_cfg1", rd, 32'h0);
    txn(1'b0, 8'h38, 32'h0, 4'hF, '0, rd);
    chk("post_rst_lock", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/glbl_reg_bank.md
# glbl_reg_bank

Parametrised global register bank, the next generation of the global config block. It adds a configurable number of read/write config registers with per-register reset values, sticky write-1-to-clear interrupt status with mask and a registered interrupt output, a write-lock, and a timed soft-reset pulse generator. It sits on the same reg-bus as the other global blocks and drives chip-level config and interrupt lines.

## Interface
- NUM_CFG, 4, number of RW config registers, 1..8, word indices 0..NUM_CFG-1
- CFG_RST, {NUM_CFG{32'h0}}, packed reset values; register k resets to CFG_RST[32k+31:32k]
- NUM_IRQ, 8, interrupt sources, 1..32
- CHIP_ID, 32'h4C66_8354, read-only word 11
- REL_DATE, 32'h1603_2022, read-only word 12
- PROJ_REV, 32'h0001_6000, read-only word 13
- SRST_CYCLES, 4, soft-reset pulse length in mclk cycles, 1..255
- mclk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- reg_cs  in  1  transaction request, held until reg_ack
- reg_wr  in  1  1 = write, 0 = read
- reg_addr  in  8  byte address; word index = reg_addr[5:2], reg_addr[7:6] ignored
- reg_wdata  in  32  write data
- reg_be  in  4  byte enables
- reg_rdata  out  32  registered read data
- reg_ack  out  1  one-cycle acknowledge
- irq_evt  in  NUM_IRQ  event pulses, synchronous to mclk, level-high sampled each cycle
- cfg_out  out  NUM_CFG*32  config register contents, packed as CFG_RST
- irq_o  out  1  registered OR of masked status
- soft_rst_n  out  1  active-low soft reset pulse
- cfg_locked  out  1  lock state

## Operation
- Address map (word index): 0..NUM_CFG-1 CFG RW; 8 IRQ_STS W1C; 9 IRQ_MASK RW; 11/12/13 CHIP_ID/REL_DATE/PROJ_REV RO; 14 LOCK (bit0, set-only); 15 SRST (write-only, reads 0). All other indices read 0, writes ignored, still acked.
- Accepted transaction = rising edge with reg_cs=1 and reg_ack=0. At that edge: reg_ack<=1, reg_rdata<=read mux value, write (if reg_wr) committed. Any other edge: reg_ack<=0, reg_rdata holds.
- Writes honour reg_be per byte. Read-only and bits at/above NUM_IRQ in STS/MASK read 0 and ignore writes.
- IRQ_STS[i] set on any edge where irq_evt[i]=1; cleared by accepted write with corresponding byte enabled and wdata bit=1. Simultaneous set and clear: set wins.
- irq_o <= |(IRQ_STS & IRQ_MASK) every edge (one-cycle registered).
- LOCK: write with be[0] and wdata[0]=1 sets lock; only reset_n clears it. While locked, writes to CFG and IRQ_MASK are dropped (still acked); IRQ_STS clear, SRST and read-only behaviour unchanged. cfg_locked = lock bit.
- SRST: write with be[0] and wdata[0]=1 loads an 8-bit down-counter with SRST_CYCLES; soft_rst_n = 0 while counter ≠ 0, registered. Write while active reloads (extends). Writes with wdata[0]=0 ignored.

## Timing
- Reset values: reg_rdata 0, reg_ack 0, cfg_out = CFG_RST, IRQ_STS 0, IRQ_MASK 0, irq_o 0, lock 0, soft_rst_n 1, counter 0.
- Latency: reg_ack high exactly one cycle after reg_cs first sampled; master holding reg_cs gets ack every second cycle, each ack a new transaction (write repeats).
- Write visibility: cfg_out / mask / lock change at the same edge reg_ack rises.
- Read returns register value before that edge.
- irq_evt at edge N -> STS bit at N -> irq_o at N+1. Mask write at edge M -> irq_o reflects at M+1.
- SRST write at edge W -> soft_rst_n low from W+1 for exactly SRST_CYCLES cycles, high again at W+1+SRST_CYCLES.
- reset_n assertion mid-transaction: all state to reset values immediately; pending transaction lost, no ack.

## Test plan
- After reset, read words 0, 11, 12, 13, 9 -> CFG_RST[31:0], 32'h4C66_8354, 32'h1603_2022, 32'h0001_6000, 0; each ack exactly one cycle after reg_cs.
- Write word 1 = 32'hDEAD_BEEF with be=4'b0101 from reset 0 -> read 32'h00AD_00EF; cfg_out[63:32] matches at ack edge.
- Pulse irq_evt[3] one cycle, mask=0 -> STS=32'h8, irq_o=0; write mask 32'h8 -> irq_o=1 next cycle; W1C 32'h8 same cycle as new irq_evt[3] -> STS stays 32'h8.
- Write LOCK=1, then CFG0=32'h1234_5678 and mask=32'hFF -> both acked, values unchanged, cfg_locked=1; STS clear still works.
- SRST_CYCLES=4: write SRST=1 -> soft_rst_n low exactly 4 cycles; rewrite at cycle 2 of pulse -> low 4 cycles from second write.
- Assert reset_n low while reg_cs high and during soft-reset pulse -> reg_ack 0, soft_rst_n 1, lock 0, cfg_out = CFG_RST immediately.
